// File: rtl/if_fetch.sv
// if_fetch: RV32I instruction-fetch stage that assembles each instruction from four byte reads.
// Revision 1.0
`default_nettype none

module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_addr_i,
  input  logic        mem_busy_i,
  input  logic [7:0]  mem_din_i,
  output logic        mem_req_o,
  output logic [31:0] mem_a_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] fetch_pc;
  logic [2:0]  issue_idx;
  logic [2:0]  recv_idx;
  logic        req_d;
  logic [7:0]  byte_buf [0:2];
  logic        capture_last;
  logic        accept;

  assign mem_a_o      = fetch_pc + {29'd0, issue_idx};
  // Reset is folded in so the request drops immediately, not at the next edge.
  assign mem_req_o    = !rst && (state == FETCH) && (issue_idx < 3'd4) && !mem_busy_i;
  assign capture_last = (state == FETCH) && req_d && (recv_idx == 3'd3);
  assign accept       = (state == DONE) && !stall_i;

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (capture_last) state_nxt = DONE;
      DONE:    if (!stall_i)     state_nxt = FETCH;
      default:                   state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc     <= RESET_PC;
      issue_idx    <= 3'd0;
      recv_idx     <= 3'd0;
      req_d        <= 1'b0;
      byte_buf[0]  <= 8'h00;
      byte_buf[1]  <= 8'h00;
      byte_buf[2]  <= 8'h00;
      pc_o         <= 32'h0;
      inst_o       <= 32'h0;
      inst_valid_o <= 1'b0;
    end else begin
      // The returned byte always belongs to last cycle's request, so busy never blocks capture.
      req_d <= mem_req_o;
      if (state == FETCH) begin
        if (mem_req_o) issue_idx <= issue_idx + 3'd1;
        if (req_d) begin
          recv_idx <= recv_idx + 3'd1;
          if (capture_last) begin
            inst_o       <= {mem_din_i, byte_buf[2], byte_buf[1], byte_buf[0]};
            pc_o         <= fetch_pc;
            inst_valid_o <= 1'b1;
          end else begin
            byte_buf[recv_idx[1:0]] <= mem_din_i;
          end
        end
      end else if (accept) begin
        fetch_pc     <= branch_flag_i ? branch_addr_i : fetch_pc + 32'd4;
        issue_idx    <= 3'd0;
        recv_idx     <= 3'd0;
        inst_valid_o <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed self-checking bench for if_fetch with a 1-cycle byte memory model.
// Revision 1.0
`default_nettype none

module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_addr_i;
  logic        mem_busy_i;
  logic [7:0]  mem_din_i;
  logic        mem_req_o;
  logic [31:0] mem_a_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [logic [31:0]];

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .branch_flag_i (branch_flag_i),
    .branch_addr_i (branch_addr_i),
    .mem_busy_i    (mem_busy_i),
    .mem_din_i     (mem_din_i),
    .mem_req_o     (mem_req_o),
    .mem_a_o       (mem_a_o),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .inst_valid_o  (inst_valid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  always @(posedge clk) mem_din_i <= mem_rd(mem_a_o);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic b, input logic s, input logic bf, input logic [31:0] ba);
    @(posedge clk);
    #1;
    mem_busy_i    = b;
    stall_i       = s;
    branch_flag_i = bf;
    branch_addr_i = ba;
    #1;
  endtask

  task automatic cyc0();
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] w);
    mem[a]         = w[7:0];
    mem[a + 32'd1] = w[15:8];
    mem[a + 32'd2] = w[23:16];
    mem[a + 32'd3] = w[31:24];
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    load_word(32'h0000_0000, 32'h0010_0513);
    load_word(32'h0000_0004, 32'h0020_0593);
    load_word(32'h0000_0008, 32'h8000_0137);
    load_word(32'h0000_000C, 32'h0000_006F);
    load_word(32'h0000_0100, 32'h0010_0093);
    load_word(32'hFFFF_FFFC, 32'h0000_0013);

    rst = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0; branch_addr_i = 32'h0; mem_busy_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req",   {31'd0, mem_req_o},    32'd0);
    check("rst_addr",  mem_a_o,               32'h0);
    check("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    check("rst_pc",    pc_o,                  32'h0);
    check("rst_inst",  inst_o,                32'h0);

    // First fetch: cycle 0 begins at reset release
    rst = 1'b0;
    #1;
    check("f0_req0",  {31'd0, mem_req_o}, 32'd1);
    check("f0_addr0", mem_a_o,            32'd0);
    for (int k = 1; k < 4; k++) begin
      cyc0();
      check("f0_req",  {31'd0, mem_req_o}, 32'd1);
      check("f0_addr", mem_a_o,            k);
    end
    cyc0();
    check("f0_c4_req",   {31'd0, mem_req_o},    32'd0);
    check("f0_c4_valid", {31'd0, inst_valid_o}, 32'd0);
    cyc0();
    check("f0_valid", {31'd0, inst_valid_o}, 32'd1);
    check("f0_inst",  inst_o,                32'h0010_0513);
    check("f0_pc",    pc_o,                  32'h0);

    // Back-to-back second fetch
    for (int c = 6; c <= 10; c++) begin
      cyc0();
      check("f1_novalid", {31'd0, inst_valid_o}, 32'd0);
      if (c == 6) check("f1_addr0", mem_a_o, 32'h4);
    end
    cyc0();
    check("f1_valid", {31'd0, inst_valid_o}, 32'd1);
    check("f1_pc",    pc_o,                  32'h4);
    check("f1_inst",  inst_o,                32'h0020_0593);

    // Busy in cycles 1-2 of the third fetch
    cyc0();
    check("bz_r0_addr", mem_a_o, 32'h8);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("bz_r1_req", {31'd0, mem_req_o}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("bz_r2_req", {31'd0, mem_req_o}, 32'd0);
    cyc0();
    check("bz_r3_req",  {31'd0, mem_req_o}, 32'd1);
    check("bz_r3_addr", mem_a_o,            32'h9);
    cyc0(); cyc0(); cyc0();
    check("bz_r6_novalid", {31'd0, inst_valid_o}, 32'd0);

    // Stall for 3 cycles starting at the valid cycle; branch ignored while stalled
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("st_valid", {31'd0, inst_valid_o}, 32'd1);
    check("st_inst",  inst_o,                32'h8000_0137);
    check("st_pc",    pc_o,                  32'h8);
    cyc(1'b0, 1'b1, 1'b1, 32'h100);
    check("st_hold_valid", {31'd0, inst_valid_o}, 32'd1);
    check("st_hold_inst",  inst_o,                32'h8000_0137);
    check("st_hold_req",   {31'd0, mem_req_o},    32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("st_hold2_pc",  pc_o,               32'h8);
    check("st_hold2_req", {31'd0, mem_req_o}, 32'd0);
    cyc0();
    check("st_rel_valid", {31'd0, inst_valid_o}, 32'd1);
    cyc0();
    check("st_next_req",  {31'd0, mem_req_o}, 32'd1);
    check("st_next_addr", mem_a_o,            32'hC);

    // Branch pulsed during FETCH has no effect
    cyc(1'b0, 1'b0, 1'b1, 32'h200);
    check("bf_fetch_addr", mem_a_o, 32'hD);
    cyc0();
    check("bf_fetch_addr2", mem_a_o, 32'hE);
    cyc0(); cyc0();
    cyc(1'b0, 1'b1, 1'b1, 32'h100);
    check("br_valid", {31'd0, inst_valid_o}, 32'd1);
    check("br_pc",    pc_o,                  32'hC);
    check("br_inst",  inst_o,                32'h0000_006F);
    cyc(1'b0, 1'b0, 1'b1, 32'h100);
    check("br_stall_norede", pc_o, 32'hC);
    check("br_stall_valid",  {31'd0, inst_valid_o}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      cyc0();
      check("br_tgt_req",  {31'd0, mem_req_o}, 32'd1);
      check("br_tgt_addr", mem_a_o,            32'h100 + k);
    end
    cyc0();
    cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    check("br_tgt_valid", {31'd0, inst_valid_o}, 32'd1);
    check("br_tgt_pc",    pc_o,                  32'h100);
    check("br_tgt_inst",  inst_o,                32'h0010_0093);

    // Fetch at the top of the address space, then wrap to 0
    for (int k = 0; k < 4; k++) begin
      cyc0();
      check("top_addr", mem_a_o, 32'hFFFF_FFFC + k);
    end
    cyc0(); cyc0();
    check("top_pc",   pc_o,   32'hFFFF_FFFC);
    check("top_inst", inst_o, 32'h0000_0013);
    cyc0();
    check("wrap_req",  {31'd0, mem_req_o}, 32'd1);
    check("wrap_addr", mem_a_o,            32'h0);
    cyc0(); cyc0(); cyc0();
    check("pre_rst_addr", mem_a_o, 32'h3);

    // Asynchronous reset after two bytes captured
    #2;
    rst = 1'b1;
    #1;
    check("arst_req",   {31'd0, mem_req_o},    32'd0);
    check("arst_addr",  mem_a_o,               32'h0);
    check("arst_pc",    pc_o,                  32'h0);
    check("arst_inst",  inst_o,                32'h0);
    check("arst_valid", {31'd0, inst_valid_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rs_req0",  {31'd0, mem_req_o}, 32'd1);
    check("rs_addr0", mem_a_o,            32'h0);
    for (int k = 1; k < 4; k++) begin
      cyc0();
      check("rs_addr", mem_a_o, k);
    end
    cyc0(); cyc0();
    check("rs_valid", {31'd0, inst_valid_o}, 32'd1);
    check("rs_inst",  inst_o,                32'h0010_0513);
    check("rs_pc",    pc_o,                  32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the 5-stage RV32I pipeline, sitting directly upstream of the IF/ID register and the decoder. It owns the program counter and fetches each 32-bit instruction as four little-endian bytes over the shared byte-wide memory port. It yields the port whenever the MEM stage holds it. It presents one instruction at a time with a valid flag, holds it under pipeline stall, and redirects to the decoder's branch/jump target (`branch_flag_i`/`branch_addr_i`).

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `stall_i` in 1: downstream cannot accept the presented instruction this cycle.
- `branch_flag_i` in 1: decoder requests redirect for the presented instruction.
- `branch_addr_i` in 32: redirect target; used as-is, no alignment check.
- `mem_busy_i` in 1: MEM stage owns the memory port this cycle; fetch must not request.
- `mem_din_i` in 8: byte returned for the request issued in the previous cycle.
- `mem_req_o` out 1: read request this cycle (combinational).
- `mem_a_o` out 32: byte address for the request (combinational).
- `pc_o` out 32: PC of the presented instruction (registered).
- `inst_o` out 32: presented instruction (registered).
- `inst_valid_o` out 1: `pc_o`/`inst_o` valid (registered).

## Operation
- Internal state:
  - `fetch_pc` (32)
  - `issue_idx` (0..4)
  - `recv_idx` (0..4)
  - `req_d` (registered `mem_req_o`)
  - byte buffer (4×8)
  - FSM {FETCH, DONE}
- Reset (async, immediate):
  - `fetch_pc`=RESET_PC, FSM=FETCH, `issue_idx`=`recv_idx`=0, `req_d`=0.
  - `pc_o`=0, `inst_o`=0, `inst_valid_o`=0.
  - `mem_req_o`=0, `mem_a_o`=RESET_PC.
  - Any partially collected bytes are discarded.
- `mem_a_o` = `fetch_pc` + `issue_idx` (mod 2^32) at all times.
- `mem_req_o` = (FSM==FETCH) && (`issue_idx`<4) && !`mem_busy_i`.
- FETCH, each cycle:
  - if `mem_req_o`: `issue_idx`++.
  - if `req_d`: buffer[`recv_idx`] ← `mem_din_i`, `recv_idx`++.
  - when the capture with `recv_idx`==3 occurs:
    - FSM→DONE
    - `inst_o` ← {`mem_din_i`, buf[2], buf[1], buf[0]}
    - `pc_o` ← `fetch_pc`
    - `inst_valid_o` ← 1
- DONE:
  - no requests issued.
  - `stall_i`=1: hold `pc_o`/`inst_o`/`inst_valid_o`; `branch_flag_i` ignored.
  - `stall_i`=0: instruction accepted at this edge.
    - `fetch_pc` ← `branch_flag_i` ? `branch_addr_i` : `fetch_pc`+4.
    - `issue_idx`, `recv_idx` ← 0.
    - FSM→FETCH.
    - `inst_valid_o` ← 0.
- `branch_flag_i`/`branch_addr_i` are sampled only in DONE with `stall_i`=0; ignored in FETCH.
- `stall_i` has no effect in FETCH; fetching proceeds.
- The memory response always belongs to the previous cycle's requester, so `mem_busy_i` never blocks capture of a byte already requested.
- PC wrap-around is modulo 2^32; 0xFFFF_FFFC+4 → 0.

## Timing
- Memory read latency is 1 cycle: the address in cycle t produces `mem_din_i` in cycle t+1.
- With no busy and no stall (cycle 0 = first FETCH cycle):
  - requests in cycles 0–3.
  - captures in cycles 1–4.
  - `inst_valid_o`=1 in cycle 5.
  - next byte-0 request in cycle 6.
  - throughput: 1 instruction per 6 cycles.
- Each busy cycle during issue delays completion by 1 cycle; byte order and contents are unaffected.
- `inst_valid_o` is a one-cycle pulse when unstalled; it stays high for the full stall duration otherwise.
- Redirect penalty: none beyond the normal 6-cycle fetch; the target's byte 0 is requested the cycle after acceptance.

## Test plan
- Reset with RESET_PC=0; mem[0..3]=13 05 10 00:
  - `mem_req_o`=1 in cycles 0–3 with `mem_a_o`=0,1,2,3.
  - cycle 5: `inst_valid_o`=1, `inst_o`=0x00100513, `pc_o`=0.
- Back-to-back fetch, no stall, mem[4..7]=93 05 20 00:
  - second valid pulse in cycle 11 with `pc_o`=4, `inst_o`=0x00200593.
  - `inst_valid_o`=0 in cycles 6–10.
- `mem_busy_i`=1 in cycles 1–2 of a fetch:
  - `mem_req_o`=0 in those cycles; address 1 is requested in cycle 3.
  - valid in cycle 7 with the same `inst_o` as unbusied.
- `stall_i`=1 for 3 cycles starting at the valid cycle:
  - `inst_o`/`pc_o`/`inst_valid_o` held.
  - `mem_req_o`=0 throughout.
  - after release, next request at `fetch_pc`+4.
- In DONE, `branch_flag_i`=1, `branch_addr_i`=0x100:
  - while `stall_i`=1: no redirect.
  - on release: requests at 0x100..0x103 and `pc_o`=0x100.
  - `branch_flag_i` pulsed during FETCH: no effect.
- Assert `rst` asynchronously after 2 bytes captured:
  - all outputs reach reset values without waiting for a clock edge.
  - after release, the fetch restarts at RESET_PC from byte 0.
  - 0xFFFF_FFFC+4 wraps to 0.
